motors_step_driver: RTL and testbench

- Responder side of the motors trigger/rdy/done handshake used by the opcode handlers; owns the X and Y stepper outputs.
- On an accepted trigger it latches one step command per axis, drives the direction lines, then emits one timed step pulse per enabled axis.
- It reports busy and completion back to the initiating handler FSM.
- All timing is counted in clk_en ticks, so step rate scales with the system enable strobe.

---
 rtl/motors_step_driver.sv | 163 ++++++++++++++++
 tb/tb_motors_step_driver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/motors_step_driver.sv
// motors_step_driver
//   Responder side of the motors trigger/rdy/done handshake. An accepted
//   trigger latches one step command per axis and drives the direction lines.
//   The block then waits a direction setup time and emits one timed step pulse
//   per enabled axis. A hold time follows before completion is reported.
//   All timing is counted in clk_en ticks.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   clk_en       advance strobe; state and counter move only when 1
//   trigger      start request, sampled only in IDLE
//   x_en/y_en    axis takes a step this command
//   x_dir_in/y_dir_in  direction for this command (1 = positive)
//   motors_rdy   ready to accept a trigger
//   motors_done  idle, or command complete
//   x_step/y_step  step pulses
//   x_dir/y_dir    latched direction outputs
module motors_step_driver #(
  parameter int DIR_SETUP_TICKS = 2,
  parameter int PULSE_TICKS     = 4,
  parameter int HOLD_TICKS      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic trigger,
  input  logic x_en,
  input  logic x_dir_in,
  input  logic y_en,
  input  logic y_dir_in,
  output logic motors_rdy,
  output logic motors_done,
  output logic x_step,
  output logic x_dir,
  output logic y_step,
  output logic y_dir
);

  localparam int MAX_A = (DIR_SETUP_TICKS > PULSE_TICKS) ? DIR_SETUP_TICKS : PULSE_TICKS;
  localparam int MAX_T = (MAX_A > HOLD_TICKS) ? MAX_A : HOLD_TICKS;
  localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CW-1:0] SETUP_LD = CW'(DIR_SETUP_TICKS - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_TICKS - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          xen_q, xen_d;
  logic          yen_q, yen_d;
  logic          xdir_q, xdir_d;
  logic          ydir_q, ydir_d;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      xen_q   <= 1'b0;
      yen_q   <= 1'b0;
      xdir_q  <= 1'b0;
      ydir_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xen_q   <= xen_d;
      yen_q   <= yen_d;
      xdir_q  <= xdir_d;
      ydir_q  <= ydir_d;
    end
  end

  // Next-state logic. Each timed state loads N-1 on entry and leaves on the
  // enabled edge where the counter reads 0, so it lasts exactly N ticks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xen_d   = xen_q;
    yen_d   = yen_q;
    xdir_d  = xdir_q;
    ydir_d  = ydir_q;
    if (clk_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (trigger) begin
            xen_d  = x_en;
            yen_d  = y_en;
            xdir_d = x_dir_in;
            ydir_d = y_dir_in;
            if (x_en || y_en) begin
              state_d = S_SETUP;
              cnt_d   = SETUP_LD;
            end else begin
              // No axis moves: complete at once, but the dirs still update.
              state_d = S_DONE;
            end
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            state_d = S_PULSE;
            cnt_d   = PULSE_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Moore outputs, decoded from the state and the latched command only.
  always_comb begin
    motors_rdy  = 1'b0;
    motors_done = 1'b0;
    x_step      = 1'b0;
    y_step      = 1'b0;
    x_dir       = xdir_q;
    y_dir       = ydir_q;
    unique case (state_q)
      S_IDLE: begin
        motors_rdy  = 1'b1;
        motors_done = 1'b1;
      end
      S_PULSE: begin
        x_step = xen_q;
        y_step = yen_q;
      end
      S_DONE:  motors_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_motors_step_driver.sv
module tb_motors_step_driver;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_en = 1'b1;
  logic trigger = 1'b0;
  logic x_en = 1'b0, x_dir_in = 1'b0, y_en = 1'b0, y_dir_in = 1'b0;
  logic motors_rdy, motors_done, x_step, x_dir, y_step, y_dir;

  int checks = 0;
  int errors = 0;

  logic div_mode = 1'b0;
  int   div = 0;

  motors_step_driver dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .trigger(trigger),
    .x_en(x_en), .x_dir_in(x_dir_in), .y_en(y_en), .y_dir_in(y_dir_in),
    .motors_rdy(motors_rdy), .motors_done(motors_done),
    .x_step(x_step), .x_dir(x_dir), .y_step(y_step), .y_dir(y_dir)
  );

  always #5 clk = ~clk;

  // clk_en either always high or high on every third clock.
  always @(negedge clk) begin
    if (div_mode) begin
      div = (div == 2) ? 0 : div + 1;
      clk_en = (div == 0);
    end else begin
      clk_en = 1'b1;
    end
  end

  task automatic chk(input string name, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, k, act, exp);
    end
  endtask

  // One record per command: inputs plus expected per-cycle masks, where bit k
  // is the output value sampled just after the k-th edge following acceptance.
  typedef struct {
    logic        xe, xd, ye, yd;
    logic        disturb;
    logic [11:0] xs_m, ys_m, rdy_m, done_m;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    x_en = v.xe; x_dir_in = v.xd; y_en = v.ye; y_dir_in = v.yd;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      chk("x_step", k, x_step, v.xs_m[k]);
      chk("y_step", k, y_step, v.ys_m[k]);
      chk("rdy",    k, motors_rdy, v.rdy_m[k]);
      chk("done",   k, motors_done, v.done_m[k]);
      chk("x_dir",  k, x_dir, v.xd);
      chk("y_dir",  k, y_dir, v.yd);
      if (v.disturb && k == 3) begin
        trigger = 1'b1;
        x_en = ~v.xe; y_en = ~v.ye; x_dir_in = ~v.xd; y_dir_in = ~v.yd;
      end
      if (v.disturb && k == 4) trigger = 1'b0;
      if (v.disturb && k == 5) trigger = 1'b1;
      if (v.disturb && k == 6) trigger = 1'b0;
    end
  endtask

  initial begin
    int hi, busy, bound;
    logic pre_en, pre_rdy;

    //          xe    xd    ye    yd    dist  x_step   y_step   rdy      done
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h03C, 12'h000, 12'h800, 12'hC00};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h03C, 12'h03C, 12'h800, 12'hC00};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h03C, 12'h03C, 12'h800, 12'hC00};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 12'hFFE, 12'hFFF};

    // Reset state
    #12;
    chk("rst_rdy", 0, motors_rdy, 1'b1);
    chk("rst_done", 0, motors_done, 1'b1);
    chk("rst_x_step", 0, x_step, 1'b0);
    chk("rst_y_step", 0, y_step, 1'b0);
    chk("rst_x_dir", 0, x_dir, 1'b0);
    chk("rst_y_dir", 0, y_dir, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Idle with trigger low stays idle and keeps dirs.
    repeat (3) @(posedge clk);
    #1;
    chk("idle_rdy", 0, motors_rdy, 1'b1);
    chk("idle_x_dir", 0, x_dir, 1'b0);
    chk("idle_y_dir", 0, y_dir, 1'b1);

    // Asynchronous reset in the middle of a pulse.
    @(negedge clk);
    x_en = 1'b1; x_dir_in = 1'b1; y_en = 1'b1; y_dir_in = 1'b1;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_x_step", 0, x_step, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_x_step", 0, x_step, 1'b0);
    chk("arst_y_step", 0, y_step, 1'b0);
    chk("arst_rdy", 0, motors_rdy, 1'b1);
    chk("arst_done", 0, motors_done, 1'b1);
    chk("arst_x_dir", 0, x_dir, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run_vec(vecs[0]);

    // clk_en every third cycle, single X step.
    div_mode = 1'b1;
    repeat (4) @(negedge clk);
    x_en = 1'b1; x_dir_in = 1'b0; y_en = 1'b0; y_dir_in = 1'b0;
    trigger = 1'b1;
    bound = 0;
    while (motors_rdy && bound < 20) begin
      @(posedge clk); #1;
      bound++;
    end
    trigger = 1'b0;
    chk("div_accept", bound, motors_rdy, 1'b0);
    hi = 0; busy = 0; bound = 0;
    while (bound < 200) begin
      pre_en = clk_en; pre_rdy = motors_rdy;
      @(posedge clk); #1;
      bound++;
      if (pre_en && !pre_rdy) busy++;
      if (x_step) hi++;
      if (motors_rdy) break;
    end
    chk("div_return", bound, motors_rdy, 1'b1);
    checks++;
    if (hi != 12) begin
      errors++;
      $display("FAIL div_x_step_len: got %0d cycles expected 12", hi);
    end
    checks++;
    if (busy != 11) begin
      errors++;
      $display("FAIL div_busy_ticks: got %0d ticks expected 11", busy);
    end
    chk("div_y_step", 0, y_step, 1'b0);
    div_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
